// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {FS_RESET, FS_REQ, FS_FULL, FS_DISCARD} fetch_state_t;
  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;
  localparam logic [31:0] FETCH_PC_STEP = 32'd4;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem read bus, decoder handshake and redirect; fetch_misaligned exists only with FETCH_MISALIGN_TRAP_EN
interface instr_fetch_unit_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic instr_valid;
  logic instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misaligned;
  modport master(output imem_req, imem_addr, instr_valid, instruction, pc, fetch_misaligned,
                 input imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc);
  modport slave(input imem_req, imem_addr, instr_valid, instruction, pc, fetch_misaligned,
                output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc);
`else
  modport master(output imem_req, imem_addr, instr_valid, instruction, pc,
                 input imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc);
  modport slave(input imem_req, imem_addr, instr_valid, instruction, pc,
                output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc);
`endif
endinterface

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: single-entry output register with valid/ready, load and flush
module fetch_out_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);
  logic valid_q, valid_d;
  logic [31:0] data_q, data_d, pc_q, pc_d;
  // flush clears only valid; data/pc keep their last contents
  always_comb begin
    valid_d = flush ? 1'b0 : load ? 1'b1 : valid_q && !ready;
    data_d = load ? load_data : data_q;
    pc_d = load ? load_pc : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= FETCH_NOP;
      pc_q <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      pc_q <= pc_d;
    end
  end
  assign valid = valid_q;
  assign data = data_q;
  assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing imem word reads and presenting instructions to decode;
// define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, target_q, target_d, rt, buf_pc;
  logic mis_q, mis_d, buf_valid, room, req, ack, kill, load, redir;
  assign redir = bus.redirect_valid;
  assign room = !buf_valid || bus.instr_ready;
  assign req = (state_q == FS_REQ && room && !mis_q) || state_q == FS_DISCARD;
  assign ack = req && bus.imem_ack;
  assign kill = redir && req && !bus.imem_ack;
  assign load = ack && state_q == FS_REQ && !redir;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign rt = bus.redirect_pc;
  assign mis_d = redir ? |bus.redirect_pc[1:0] : mis_q;
  assign bus.fetch_misaligned = mis_q;
  assign bus.pc = mis_q ? target_q : buf_pc;
`else
  assign rt = bus.redirect_pc & ~32'd3;
  assign mis_d = 1'b0;
  assign bus.pc = buf_pc;
`endif
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d = redir ? rt : target_q;
    case (state_q)
      FS_RESET: begin
        state_d = FS_REQ;
        fetch_pc_d = RESET_PC;
      end
      FS_REQ: begin
        state_d = kill ? FS_DISCARD : !redir && !room ? FS_FULL : FS_REQ;
        fetch_pc_d = kill ? fetch_pc_q : redir ? rt : ack ? fetch_pc_q + FETCH_PC_STEP : fetch_pc_q;
      end
      FS_FULL: begin
        state_d = redir || bus.instr_ready ? FS_REQ : FS_FULL;
        fetch_pc_d = redir ? rt : fetch_pc_q;
      end
      FS_DISCARD: begin
        state_d = bus.imem_ack ? FS_REQ : FS_DISCARD;
        fetch_pc_d = bus.imem_ack ? target_d : fetch_pc_q;
      end
      default: state_d = FS_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_RESET;
      fetch_pc_q <= RESET_PC;
      target_q <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q <= target_d;
      mis_q <= mis_d;
    end
  end
  fetch_out_buf #(.RESET_PC(RESET_PC)) u_buf (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(redir),
    .ready(bus.instr_ready),
    .load_data(bus.imem_rdata),
    .load_pc(fetch_pc_q),
    .valid(buf_valid),
    .data(bus.instruction),
    .pc(buf_pc)
  );
  assign bus.imem_req = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.instr_valid = buf_valid;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: per-cycle vector table with a transfer scoreboard, plus reset sequences
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_unit_if bus();
  instr_fetch_unit #(.RESET_PC(32'h100)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic rdy, ack, redir;
    logic [31:0] rpc;
    logic keep, req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] pc;
    logic mis;
  } vec_t;
  typedef struct packed {
    logic [31:0] pc, ins;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a ^ 32'h1357_0000;
  endfunction
  function automatic vec_t mk(input logic rdy, ack, redir, input logic [31:0] rpc, input logic keep,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic mis = 1'b0);
    return '{rdy, ack, redir, rpc, keep, req, addr, vld, pc, mis};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk_mis(input string name, input logic exp);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk(name, 32'(bus.fetch_misaligned), 32'(exp));
`else
    if (exp) chk(name, 32'd0, 32'd1);
`endif
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " imem_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, " imem_addr"}, bus.imem_addr, 32'h100);
    chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, " instruction"}, bus.instruction, 32'h13);
    chk({tag, " pc"}, bus.pc, 32'h100);
    chk_mis({tag, " misaligned"}, 1'b0);
  endtask
  task automatic apply(input int i, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready = v.rdy;
    bus.redirect_valid = v.redir;
    bus.redirect_pc = v.rpc;
    bus.imem_ack = v.ack;
    bus.imem_rdata = mem(v.addr);
    #1;
    chk($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(v.req));
    chk($sformatf("v%0d imem_addr", i), bus.imem_addr, v.addr);
    chk($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(v.vld));
    chk($sformatf("v%0d pc", i), bus.pc, v.pc);
    chk_mis($sformatf("v%0d misaligned", i), v.mis);
    if (bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        chk($sformatf("v%0d unexpected transfer pc", i), bus.pc, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d xfer pc", i), bus.pc, e.pc);
        chk($sformatf("v%0d xfer instruction", i), bus.instruction, e.ins);
      end
    end
    if (v.ack && v.keep) sb.push_back('{v.addr, mem(v.addr)});
  endtask
  initial begin
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    // streaming from reset, then a 3-cycle decoder stall
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h100, 0, 32'h100));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h100, 0, 32'h100));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h104, 1, 32'h100));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h108, 1, 32'h104));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h10C, 1, 32'h108));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h10C, 1, 32'h108));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h10C, 1, 32'h108));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h10C, 1, 32'h108));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h10C, 0, 32'h108));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h110, 1, 32'h10C));
    // redirect while 0x114 is outstanding: old address held, its data dropped
    vecs.push_back(mk(1, 0, 1, 32'h200, 0, 1, 32'h114, 1, 32'h110));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h114, 0, 32'h110));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 32'h114, 0, 32'h110));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h200, 0, 32'h110));
    // redirect coincident with ack, then 0x40 over the ack of 0x10
    vecs.push_back(mk(1, 1, 1, 32'h10, 0, 1, 32'h204, 1, 32'h200));
    vecs.push_back(mk(1, 1, 1, 32'h40, 0, 1, 32'h010, 0, 32'h200));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h040, 0, 32'h200));
    // wrap from the top of the address space
    vecs.push_back(mk(1, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'h044, 1, 32'h040));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h040));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h0, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h8, 1, 32'h4));
    vecs.push_back(mk(1, 0, 1, 32'h102, 0, 0, 32'h8, 1, 32'h4));
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h102, 0, 32'h102, 1));
    vecs.push_back(mk(1, 0, 1, 32'h300, 0, 0, 32'h102, 0, 32'h102, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h300, 0, 32'h4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h304, 1, 32'h300));
`else
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h100, 0, 32'h4));
    vecs.push_back(mk(1, 1, 1, 32'h300, 0, 1, 32'h104, 1, 32'h100));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h300, 0, 32'h100));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h304, 1, 32'h300));
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset("reset");
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    // reset with 0x304 still outstanding, then release
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_reset("mid reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release cycle imem_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("first req after release", 32'(bus.imem_req), 32'd1);
    chk("first addr after release", bus.imem_addr, 32'h100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
